// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write arbiter.
// Optional statistics are built when FIFO_ARB_STATS_EN is defined.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    // Beat counter width within one grant tenure
    localparam int BEAT_W  = 4;
    // Per-requester granted-beat statistics counter width
    localparam int STATS_W = 16;
    // Width of owner / round-robin pointer (up to 8 requesters)
    localparam int OWNER_W = 3;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner search: first requester at or after ptr, wrapping
// from NUM_REQ-1 back to 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               vld,
    output logic [OWNER_W-1:0] idx
);

    logic [NUM_REQ-1:0] rot;

    // ptr + off folded back into 0..NUM_REQ-1
    function automatic logic [OWNER_W-1:0] wrap_add(input logic [OWNER_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return OWNER_W'(s);
    endfunction

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        vld = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                vld = 1'b1;
                idx = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multi-requester FIFO write arbiter with round-robin tenures of up to
// BURST_MAX beats, stalling on FIFO full and ending early on almost-full.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wrdata,
    output logic [NUM_REQ-1:0]            o_gnt,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_alm_full,
    output logic                          o_fifo_wren,
    output logic [DATA_WIDTH-1:0]         o_fifo_wrdata,
    output logic [OWNER_W-1:0]            o_owner,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*STATS_W-1:0]    o_gnt_cnt,
`endif
    output logic                          o_busy
);

    localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(BURST_MAX);

    arb_state_t          state, state_nxt;
    logic [OWNER_W-1:0]  owner, owner_nxt;
    logic [OWNER_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [OWNER_W-1:0]  owner_inc;
    logic                owner_req;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                grant_ok;
    logic                end_tenure;
    logic                pick_vld;
    logic [OWNER_W-1:0]  pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (i_req),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign owner_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 3'd1;

    // Select the current owner's request bit and data slice
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(owner) == k) begin
                owner_req  = i_req[k];
                owner_data = i_wrdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Combinational grant and FIFO write outputs; everything forced low during reset
    always_comb begin
        grant_ok = (state == ST_BURST) && owner_req && !i_fifo_full && !rstn;
        o_gnt    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(owner) == k) o_gnt[k] = grant_ok;
        end
        o_fifo_wren   = grant_ok;
        o_fifo_wrdata = grant_ok ? owner_data : '0;
        o_owner       = rstn ? '0 : owner;
        o_busy        = !rstn && (state != ST_IDLE);
    end

    // Next-state logic: selection, beat counting, stall and tenure end
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        end_tenure   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld && !i_fifo_full) begin
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!owner_req) begin
                    end_tenure = 1'b1;
                end else if (i_fifo_full) begin
                    state_nxt = ST_STALL;
                end else begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                    if (beat_cnt_nxt == BURST_LAST || i_fifo_alm_full) end_tenure = 1'b1;
                end
            end
            ST_STALL: begin
                if (!owner_req) begin
                    end_tenure = 1'b1;
                end else if (!i_fifo_full) begin
                    state_nxt = ST_BURST;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A finished tenure hands priority to the next requester in line
        if (end_tenure) begin
            state_nxt    = ST_IDLE;
            rr_ptr_nxt   = owner_inc;
            beat_cnt_nxt = '0;
        end
    end

    // State, owner, round-robin pointer and beat counter registers
    always_ff @(posedge clk) begin
        if (rstn) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [STATS_W-1:0] cnt;
        // Saturating count of beats granted to requester g
        always_ff @(posedge clk) begin
            if (rstn)          cnt <= '0;
            else if (o_gnt[g]) cnt <= sat_inc(cnt);
        end
        assign o_gnt_cnt[g*STATS_W +: STATS_W] = cnt;
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed vector table, round-robin order
// sequence, randomized run against a tenure-level model, and (when
// FIFO_ARB_STATS_EN is defined) counter saturation.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BM = 4;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         full;
        logic         alm;
        logic [N-1:0] gnt;
        logic [2:0]   owner;
        logic         busy;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    i_req;
    logic [N*DW-1:0] i_wrdata;
    logic [N-1:0]    o_gnt;
    logic            i_fifo_full;
    logic            i_fifo_alm_full;
    logic            o_fifo_wren;
    logic [DW-1:0]   o_fifo_wrdata;
    logic [2:0]      o_owner;
    logic            o_busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] o_gnt_cnt;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    int   order_q[$];

    // Tenure-level reference model state
    int m_tenure, m_stall, m_owner, m_beats, m_rr;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_req           (i_req),
        .i_wrdata        (i_wrdata),
        .o_gnt           (o_gnt),
        .i_fifo_full     (i_fifo_full),
        .i_fifo_alm_full (i_fifo_alm_full),
        .o_fifo_wren     (o_fifo_wren),
        .o_fifo_wrdata   (o_fifo_wrdata),
        .o_owner         (o_owner),
`ifdef FIFO_ARB_STATS_EN
        .o_gnt_cnt       (o_gnt_cnt),
`endif
        .o_busy          (o_busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sel_data(input logic [N*DW-1:0] d, input logic [N-1:0] g);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) if (g[k]) r = d[k*DW +: DW];
        return r;
    endfunction

    task automatic check_outs(input string tag, input logic [N-1:0] e_gnt,
                              input logic [2:0] e_owner, input logic e_busy);
        chk({tag, ".gnt"},    64'(o_gnt),         64'(e_gnt));
        chk({tag, ".wren"},   64'(o_fifo_wren),   64'(|e_gnt));
        chk({tag, ".wrdata"}, 64'(o_fifo_wrdata), 64'(sel_data(i_wrdata, e_gnt)));
        chk({tag, ".owner"},  64'(o_owner),       64'(e_owner));
        chk({tag, ".busy"},   64'(o_busy),        64'(e_busy));
    endtask

    task automatic row(input logic r, input logic [N-1:0] q, input logic f, input logic a,
                       input logic [N-1:0] g, input logic [2:0] o, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.alm = a;
        v.gnt = g; v.owner = o; v.busy = b;
        tbl.push_back(v);
    endtask

    // One cycle of the reference: outputs from the current tenure, then advance.
    task automatic model_step(input logic [N-1:0] req, input logic full, input logic alm,
                              input logic rst, output logic [N-1:0] e_gnt,
                              output logic [2:0] e_owner, output logic e_busy);
        int  best;
        bit  done;
        done    = 0;
        e_gnt   = '0;
        e_owner = rst ? 3'd0 : 3'(m_owner);
        e_busy  = !rst && (m_tenure != 0);
        if (rst) begin
            m_tenure = 0; m_stall = 0; m_owner = 0; m_beats = 0; m_rr = 0;
        end else if (m_tenure == 0) begin
            if (req != 0 && !full) begin
                // winner = requester with smallest circular distance from rr
                best = -1;
                for (int k = 0; k < N; k++)
                    if (req[k] && (best < 0 || (k - m_rr + N) % N < (best - m_rr + N) % N))
                        best = k;
                m_owner = best; m_tenure = 1; m_stall = 0; m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            done = 1;
        end else if (m_stall != 0) begin
            if (!full) m_stall = 0;
        end else if (full) begin
            m_stall = 1;
        end else begin
            e_gnt[m_owner] = 1'b1;
            m_beats++;
            if (m_beats == BM || alm) done = 1;
        end
        if (done) begin
            m_tenure = 0; m_stall = 0; m_beats = 0;
            m_rr = (m_owner + 1) % N;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] e_gnt;
        logic [2:0]   e_owner;
        logic         e_busy;
        logic [N-1:0] rq;
        logic         rr, ff, aa;
        int           idx;

        rstn = 1'b1; i_req = '0; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
        for (int k = 0; k < N; k++) i_wrdata[k*DW +: DW] = 16'h1111 * 16'(k + 1);
        repeat (2) @(posedge clk);
        #1;

        // rst, req, full, alm, gnt, owner, busy
        row(1, 4'b0001, 0, 0, 4'b0000, 0, 0);   // reset state
        row(0, 4'b0001, 0, 0, 4'b0000, 0, 0);   // select 0
        row(0, 4'b0001, 0, 0, 4'b0001, 0, 1);
        row(0, 4'b0001, 0, 0, 4'b0001, 0, 1);
        row(0, 4'b0001, 0, 0, 4'b0001, 0, 1);
        row(0, 4'b0001, 0, 0, 4'b0001, 0, 1);   // 4th beat -> idle, rr=1
        row(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        row(0, 4'b1111, 0, 0, 4'b0000, 0, 0);   // select 1
        row(0, 4'b1111, 0, 1, 4'b0010, 1, 1);   // almost-full on beat 1
        row(0, 4'b1111, 0, 0, 4'b0000, 1, 0);   // select 2
        row(0, 4'b1111, 0, 0, 4'b0100, 2, 1);
        row(0, 4'b1111, 0, 0, 4'b0100, 2, 1);
        row(0, 4'b1111, 1, 0, 4'b0000, 2, 1);   // full -> stall
        row(0, 4'b1111, 1, 0, 4'b0000, 2, 1);
        row(0, 4'b1111, 1, 0, 4'b0000, 2, 1);
        row(0, 4'b1111, 0, 0, 4'b0000, 2, 1);   // full falls, back to burst
        row(0, 4'b1111, 0, 0, 4'b0100, 2, 1);   // beat 3
        row(0, 4'b1111, 0, 0, 4'b0100, 2, 1);   // beat 4
        row(0, 4'b1111, 0, 0, 4'b0000, 2, 0);   // select 3
        row(0, 4'b1111, 0, 0, 4'b1000, 3, 1);
        row(0, 4'b1111, 0, 0, 4'b1000, 3, 1);
        row(1, 4'b1111, 0, 0, 4'b0000, 0, 0);   // reset during beat 3
        row(0, 4'b1111, 0, 0, 4'b0000, 0, 0);   // select restarts at 0
        row(0, 4'b1111, 0, 0, 4'b0001, 0, 1);
        row(0, 4'b1110, 0, 0, 4'b0000, 0, 1);   // owner drops
        row(0, 4'b1110, 0, 0, 4'b0000, 0, 0);   // select 1
        row(0, 4'b1110, 0, 0, 4'b0010, 1, 1);
        row(0, 4'b0000, 0, 0, 4'b0000, 1, 1);   // owner drops
        row(0, 4'b1111, 1, 0, 4'b0000, 1, 0);   // full in idle: no selection
        row(0, 4'b1111, 0, 0, 4'b0000, 1, 0);   // select 2
        row(0, 4'b1111, 0, 0, 4'b0100, 2, 1);
        row(0, 4'b1111, 1, 0, 4'b0000, 2, 1);   // -> stall
        row(0, 4'b1011, 1, 0, 4'b0000, 2, 1);   // drop while stalled
        row(0, 4'b0000, 0, 0, 4'b0000, 2, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rstn = tbl[i].rst; i_req = tbl[i].req;
            i_fifo_full = tbl[i].full; i_fifo_alm_full = tbl[i].alm;
            @(negedge clk);
            check_outs($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].busy);
            @(posedge clk);
            #1;
        end

        // Round-robin order with all requesters held
        rstn = 1'b1; i_req = '0; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0; i_req = 4'b1111;
        for (int c = 0; c < 40 && order_q.size() < 20; c++) begin
            @(negedge clk);
            chk("rr.onehot", 64'($countones(o_gnt) > 1), 64'(0));
            if (o_gnt != 0) begin
                idx = 0;
                for (int k = 0; k < N; k++) if (o_gnt[k]) idx = k;
                order_q.push_back(idx);
            end
            @(posedge clk);
            #1;
        end
        chk("rr.beats", 64'(order_q.size()), 64'(20));
        for (int t = 0; t < order_q.size(); t++)
            chk($sformatf("rr.order%0d", t), 64'(order_q[t]), 64'((t / BM) % N));

        // Randomized run against the tenure model
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
            rr = (c == 0) || ($urandom_range(0, 199) == 0);
            ff = ($urandom_range(0, 9) < 2);
            aa = ($urandom_range(0, 9) < 1);
            rstn = rr; i_req = rq; i_fifo_full = ff; i_fifo_alm_full = aa;
            i_wrdata = {$urandom, $urandom};
            @(negedge clk);
            model_step(rq, ff, aa, rr, e_gnt, e_owner, e_busy);
            check_outs($sformatf("rnd%0d", c), e_gnt, e_owner, e_busy);
            @(posedge clk);
            #1;
        end

`ifdef FIFO_ARB_STATS_EN
        begin
            int beats;
            bit mid_done;
            beats = 0;
            mid_done = 0;
            rstn = 1'b1; i_req = '0; i_fifo_full = 1'b0; i_fifo_alm_full = 1'b0;
            @(posedge clk);
            #1;
            chk("stats.reset", 64'(o_gnt_cnt), 64'(0));
            rstn = 1'b0; i_req = 4'b0001;
            for (int c = 0; c < 90000 && beats < 65540; c++) begin
                @(negedge clk);
                if (o_gnt[0]) beats++;
                @(posedge clk);
                #1;
                if (beats == 300 && !mid_done) begin
                    mid_done = 1;
                    chk("stats.mid", 64'(o_gnt_cnt[15:0]), 64'(300));
                end
            end
            i_req = '0;
            chk("stats.beats", 64'(beats), 64'(65540));
            @(negedge clk);
            chk("stats.sat0", 64'(o_gnt_cnt[15:0]), 64'(16'hFFFF));
            chk("stats.cnt1", 64'(o_gnt_cnt[31:16]), 64'(0));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 128, SHALL set the per-requester write data width.
REQ-003 Parameter BURST_MAX, default 4, SHALL set the maximum beats per grant tenure (1..15).
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rstn  input  1  SHALL be a synchronous, active-high reset (asserted = 1, sampled on rising clk).
REQ-006 i_req  input  NUM_REQ  SHALL carry per-requester write requests, one bit per requester.
REQ-007 i_wrdata  input  NUM_REQ*DATA_WIDTH  SHALL carry packed write data; requester k occupies slice k.
REQ-008 o_gnt  output  NUM_REQ  SHALL be one-hot or zero; a bit high means that requester's beat is accepted this cycle.
REQ-009 i_fifo_full, i_fifo_alm_full  input  1 each  SHALL carry the FIFO full and almost-full flags.
REQ-010 o_fifo_wren  output  1  SHALL be the FIFO write enable.
REQ-011 o_fifo_wrdata  output  DATA_WIDTH  SHALL be the FIFO write data.
REQ-012 o_owner  output  3  SHALL carry the index of the current tenure owner; o_busy  output  1  SHALL be high outside IDLE.

Function
REQ-013 FSM states SHALL be IDLE, BURST and STALL.
REQ-014 In IDLE with any i_req high and i_fifo_full low, the arbiter SHALL register the winner and enter BURST next cycle; the first grant comes one cycle after selection.
REQ-015 Winner selection SHALL be round-robin: search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
REQ-016 In IDLE with i_fifo_full high, no selection SHALL occur.
REQ-017 In BURST, o_gnt[owner] SHALL equal i_req[owner] AND NOT i_fifo_full (combinational); all other bits SHALL be 0.
REQ-018 o_fifo_wren SHALL equal OR of o_gnt; o_fifo_wrdata SHALL equal the owner's slice (zero when wren low).
REQ-019 Each granted beat SHALL increment a 4-bit beat counter.
REQ-020 Tenure SHALL end (to IDLE, rr_ptr <= owner+1 mod NUM_REQ, beat counter cleared) when any of these holds: the beat count reaches BURST_MAX, the owner drops i_req, or a beat is granted while i_fifo_alm_full is high.
REQ-021 In BURST with i_req[owner] high and i_fifo_full high, the FSM SHALL enter STALL, keeping the owner and beat count.
REQ-022 STALL SHALL return to BURST when i_fifo_full falls; owner drop in STALL SHALL end tenure as per REQ-020.
REQ-023 Simultaneous requests SHALL never produce more than one grant bit; a requester with i_req high SHALL be granted within NUM_REQ tenures while the FIFO is not full.

Reset
REQ-024 On rstn high: state IDLE, rr_ptr 0, beat counter 0, o_owner 0, o_busy 0, o_gnt 0, o_fifo_wren 0, o_fifo_wrdata 0.
REQ-025 Reset asserted mid-tenure SHALL abort the tenure without a further grant in the reset cycle.

Configuration
REQ-026 With macro FIFO_ARB_STATS_EN defined, output o_gnt_cnt (NUM_REQ*16) SHALL provide per-requester 16-bit saturating granted-beat counters, cleared by reset.
REQ-027 Without FIFO_ARB_STATS_EN, the port and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the FSM state enum, the beat counter width constant (4) and the stats counter width (16).
REQ-029 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, rr_ptr; outputs: valid, index).

Verification
REQ-030 Reset, then i_req=4'b0001, FIFO empty -> grant to 0 for 4 consecutive beats starting 1 cycle after request, then IDLE, rr_ptr=1.
REQ-031 i_req=4'b1111 held, FIFO never full -> tenure order 0,1,2,3,0, each 4 beats, no overlapping grants.
REQ-032 Owner 2 in BURST, i_fifo_full high for 3 cycles after beat 2 -> STALL 3 cycles, o_gnt=0, resumes with beats 3-4, owner still 2.
REQ-033 i_fifo_alm_full high at beat 1 of owner 1 -> tenure ends after 1 beat, next owner 2.
REQ-034 rstn pulsed during beat 3 of owner 3 -> all outputs 0 in the reset cycle, next selection starts from requester 0.
REQ-035 FIFO_ARB_STATS_EN defined, 70000 granted beats to requester 0 -> o_gnt_cnt[0] saturates at 65535.
